// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one shared resource to one of N requesters at a time.
// Latency: request to grant is 1 cycle from IDLE/GAP; one all-zero gap cycle separates owners.
// Backpressure: an owner holds the grant until it releases, drops req, or hits MAX_HOLD.
//
// Ports:
//   i_clock, i_reset    - clock and synchronous active-high reset
//   i_req[N]            - request levels, held high while wanting/holding the resource
//   i_rel[N]            - release pulses, only the current owner's bit is looked at
//   o_grant[N]          - registered one-hot grant (zero when idle or in the gap)
//   o_owner[IDX_W]      - index of the current grantee, 0 when not busy
//   o_busy              - high while any grant bit is high
//   o_expired           - one-cycle pulse in the gap that follows a hold-limit revoke
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_rel,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_owner,
    output logic             o_busy,
    output logic             o_expired
);

    // A zero-width counter is not legal, so the disabled-limit case keeps one bit.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_grant;
    logic [IDX_W-1:0] r_owner;
    logic             r_busy;
    logic             r_expired;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [N-1:0]     w_grant_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic             w_busy_nxt;
    logic             w_expired_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_ptr_after;
    logic             w_end_rel;
    logic             w_end_lim;

    // Pick the requester closest to r_ptr going upward (mod N): the one with
    // the smallest rotational distance from the pointer wins.
    always_comb begin
        int d;
        int best_d;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        d          = 0;
        best_d     = N;
        for (int j = 0; j < N; j++) begin
            if (i_req[j]) begin
                d = j - int'(r_ptr);
                if (d < 0) d = d + N;
                if (d < best_d) begin
                    best_d     = d;
                    w_pick_vld = 1'b1;
                    w_pick_idx = IDX_W'(j);
                end
            end
        end
    end

    // The pointer moves past the outgoing owner so it becomes lowest priority.
    assign w_ptr_after = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;

    // Release beats the hold limit when both land on the same cycle.
    assign w_end_rel = i_rel[r_owner] | ~i_req[r_owner];
    assign w_end_lim = (MAX_HOLD != 0) && (r_cnt == HOLD_LIM);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_busy_nxt    = r_busy;
        w_expired_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = N'(1) << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_end_rel || w_end_lim) begin
                    w_state_nxt   = ST_GAP;
                    w_grant_nxt   = '0;
                    w_owner_nxt   = '0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = w_ptr_after;
                    w_cnt_nxt     = '0;
                    w_expired_nxt = ~w_end_rel;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_busy    <= w_busy_nxt;
            r_expired <= w_expired_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_grant   = r_grant;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;
    assign o_expired = r_expired;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       expired;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(8)) dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_req    (req),
        .i_rel    (rel),
        .o_grant  (grant),
        .o_owner  (owner),
        .o_busy   (busy),
        .o_expired(expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Busy is always derived from the expected grant, not from the DUT.
    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic x);
        chk({tag, ".grant"},   32'(grant),   32'(g));
        chk({tag, ".owner"},   32'(owner),   32'(o));
        chk({tag, ".busy"},    32'(busy),    32'(|g));
        chk({tag, ".expired"}, 32'(expired), 32'(x));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        rel = 4'b0000;

        // Reset held with all requests pending.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset", 4'b0000, 2'd0, 1'b0);
        end
        rst = 1'b0;
        step();
        chk_all("first_grant", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();
        chk_all("drop_gap", 4'b0000, 2'd0, 1'b0);
        step();
        chk_all("idle", 4'b0000, 2'd0, 1'b0);

        // Single requester with a foreign release ignored.
        req = 4'b0100;
        step();
        chk_all("single", 4'b0100, 2'd2, 1'b0);
        rel = 4'b0010;
        step();
        chk_all("foreign_rel", 4'b0100, 2'd2, 1'b0);
        rel = 4'b0100;
        step();
        chk_all("own_rel", 4'b0000, 2'd0, 1'b0);
        rel = 4'b0000;
        req = 4'b0000;
        step();
        chk_all("single_idle", 4'b0000, 2'd0, 1'b0);

        // Rotation from a freshly reset pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_all("rot_c1", 4'(1 << i), 2'(i), 1'b0);
            step();
            chk_all("rot_c2", 4'(1 << i), 2'(i), 1'b0);
            rel = 4'(1 << i);
            step();
            rel = 4'b0000;
            chk_all("rot_gap", 4'b0000, 2'd0, 1'b0);
            step();
        end
        chk_all("rot_wrap", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();
        step();
        chk_all("rot_idle", 4'b0000, 2'd0, 1'b0);

        // Hold limit: 8 grant cycles, expired gap, then re-grant.
        req = 4'b0010;
        step();
        chk_all("to_c1", 4'b0010, 2'd1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_all("to_hold", 4'b0010, 2'd1, 1'b0);
        end
        step();
        chk_all("to_expired", 4'b0000, 2'd0, 1'b1);
        step();
        chk_all("to_regrant", 4'b0010, 2'd1, 1'b0);

        // Release on the 8th cycle beats the limit.
        for (int c = 2; c <= 8; c++) step();
        chk_all("sim_c8", 4'b0010, 2'd1, 1'b0);
        rel = 4'b0010;
        step();
        rel = 4'b0000;
        chk_all("sim_rel_wins", 4'b0000, 2'd0, 1'b0);
        step();
        chk_all("sim_regrant", 4'b0010, 2'd1, 1'b0);
        step();
        req = 4'b0000;
        step();
        chk_all("sim_req_drop", 4'b0000, 2'd0, 1'b0);
        step();

        // Reset during the 4th cycle of a grant to requester 3.
        req = 4'b1000;
        for (int c = 1; c <= 4; c++) step();
        chk_all("mid_c4", 4'b1000, 2'd3, 1'b0);
        rst = 1'b1;
        req = 4'b1010;
        step();
        chk_all("mid_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("post_reset", 4'b0010, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one clocked resource among `N` requesters. It grants exclusive ownership to one requester at a time. Each grant lasts until the owner releases it, drops its request, or overruns a hold-time limit. A one-cycle gap is inserted between owners. The block sits between the requesting units and the shared resource; `grant` drives the resource's input select and enable logic.

## Interface
- `N`, 4: number of requesters.
- `IDX_W`, 2: width of the owner index; must satisfy 2^IDX_W >= N.
- `MAX_HOLD`, 8: maximum consecutive cycles a grant may stay high before it is revoked; 0 disables the limit.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester request level; must stay high while the requester wants or holds the resource.
- `rel`  in  N  per-requester release pulse; only the current owner's bit is honoured.
- `grant`  out  N  one-hot grant (all zero when idle); registered.
- `owner`  out  IDX_W  index of the current grantee; 0 when `busy`=0.
- `busy`  out  1  high while any grant bit is high.
- `expired`  out  1  one-cycle pulse when a grant is revoked by the `MAX_HOLD` limit.

## Operation
- Reset values: `grant`=0, `owner`=0, `busy`=0, `expired`=0, rotation pointer `ptr`=0, hold counter=0, state IDLE.
- FSM states: IDLE, GRANT, GAP. All outputs are registered and decoded from the state registers.
- IDLE:
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, … modulo N.
  - Load `grant`=1<<i, `owner`=i, `busy`=1, counter=1, and go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT:
  - End the grant if `rel[owner]`=1 or `req[owner]`=0. This is a normal release: go to GAP.
  - Otherwise, if `MAX_HOLD`≠0 and counter=`MAX_HOLD`, revoke the grant: go to GAP and set `expired`=1.
  - Otherwise, increment the counter and stay in GRANT.
  - `rel` bits of non-owners are ignored.
  - `req` changes from other requesters have no effect until arbitration.
- Entering GAP:
  - Clear `grant`, `busy`, and `owner`.
  - Set `ptr`=(old owner+1) mod N; this makes the last owner the lowest priority.
- GAP (exactly one cycle):
  - Arbitrate exactly as in IDLE using the new `ptr`.
  - Go to GRANT if any request is pending, else to IDLE.
  - `expired` returns to 0 at the end of GAP.
- Release and limit in the same cycle: the release wins and `expired` stays 0.
- Counter width is clog2(`MAX_HOLD`+1). When `MAX_HOLD`=0 the counter saturates and is unused.
- `reset` high overrides everything in any state, including mid-grant and during GAP. All outputs take their reset values at that edge.
- Invariant: `grant` is one-hot or zero at every cycle; `busy` equals |`grant`.

## Timing
- Request to grant from IDLE: `req[i]` high before edge E means `grant[i]` is high in the cycle after E (1-cycle latency).
- Release to grant drop: `rel[owner]` sampled at edge E means `grant` is 0 in the cycle after E.
- Handover: exactly one all-zero gap cycle separates successive grants. Back-to-back owners therefore see grant, 0, grant.
- Hold limit: a grant stays high for at most `MAX_HOLD` cycles. `expired` is high in the gap cycle that immediately follows the last grant cycle.
- Fairness: with all `N` requests held continuously, each requester receives a grant within N·(`MAX_HOLD`+1) cycles.

## Test plan
All scenarios use `N`=4 and `MAX_HOLD`=8.
- **Reset:** `reset`=1 for 3 cycles with `req`=4'b1111 → `grant`=0, `busy`=0, `owner`=0, `expired`=0 throughout. The first grant after reset is 4'b0001.
- **Single requester:** `req`=4'b0100 → `grant`=4'b0100, `owner`=2, `busy`=1 one edge later. Pulse `rel[2]` → `grant`=0 next cycle. A `rel[1]` pulse sent while 2 owns the grant has no effect.
- **Rotation:** `req`=4'b1111 held, each owner pulses `rel` on its 2nd grant cycle → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles and is separated by exactly one zero cycle.
- **Timeout:** `req`=4'b0010 held, no `rel` → `grant`=0010 for exactly 8 cycles, then 1 cycle with `grant`=0 and `expired`=1, then `grant`=0010 again.
- **Simultaneous events:** `rel[owner]` asserted in the 8th grant cycle → grant drops and `expired` stays 0. Separately, `req[owner]` dropped mid-grant → grant drops next cycle.
- **Reset mid-operation:** assert `reset` during the 4th cycle of a grant to requester 3 → next cycle all outputs are 0. After `reset` falls with `req`=4'b1010, the grant goes to requester 1 (`ptr` was reset to 0).
